// File: rtl/sar_dout_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sar_dout_fifo
// Purpose  : Captures each completed SAR conversion result on the rising edge
//            of the sar_logic ready flag and buffers it in a small FIFO with a
//            valid/ready handshake toward the readout side. Counts accepted
//            conversions and keeps a sticky flag for dropped ones.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1        system clock, shared with sar_logic
//   rstb       in   1        asynchronous active-low reset
//   ready      in   1        end-of-conversion flag (level)
//   dout       in   ADC_BIT  conversion result, stable while ready=1
//   out_ready  in   1        consumer accepts out_data this cycle
//   ovf_clr    in   1        synchronous clear of sticky ovf
//   out_valid  out  1        out_data holds the FIFO head
//   out_data   out  ADC_BIT  FIFO head word
//   level      out  AW+1     current occupancy, 0..DEPTH
//   ovf        out  1        sticky: at least one conversion dropped
//   conv_cnt   out  CNT_W    accepted conversions, modulo 2^CNT_W
// ============================================================================
module sar_dout_fifo #(
  parameter int ADC_BIT = 11,
  parameter int DEPTH   = 4,
  parameter int AW      = 2,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               ready,
  input  logic [ADC_BIT-1:0] dout,
  input  logic               out_ready,
  input  logic               ovf_clr,
  output logic               out_valid,
  output logic [ADC_BIT-1:0] out_data,
  output logic [AW:0]        level,
  output logic               ovf,
  output logic [CNT_W-1:0]   conv_cnt
);

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [ADC_BIT-1:0] mem [DEPTH];
  logic [AW-1:0]      wptr;
  logic [AW-1:0]      rptr;
  logic               ready_q;

  logic push_req;
  logic pop;
  logic full;
  logic push_ok;
  logic drop;

  // One push per conversion: only the low-to-high transition of ready counts.
  assign push_req = ready & ~ready_q;
  assign pop      = out_valid & out_ready;
  assign full     = (level == FULL_LEVEL);
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign push_ok  = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  assign out_valid = (level != '0);
  assign out_data  = mem[rptr];

  // ready_q resets high so a ready already asserted when reset is released
  // is treated as stale and does not capture a word.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ready_q <= 1'b1;
    end else begin
      ready_q <= ready;
    end
  end

  // Storage array; cleared on reset so the empty head reads as zero.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push_ok) begin
      mem[wptr] <= dout;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

  // Occupancy: simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      level <= '0;
    end else begin
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      conv_cnt <= '0;
    end else if (push_ok) begin
      conv_cnt <= conv_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sar_dout_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sar_dout_fifo
// Purpose  : Self-checking bench for sar_dout_fifo. Expected words are queued
//            when a conversion is driven and compared as the consumer pops.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sar_dout_fifo;

  localparam int ADC_BIT = 11;
  localparam int DEPTH   = 4;
  localparam int AW      = 2;
  localparam int CNT_W   = 8;

  logic               clk;
  logic               rstb;
  logic               ready;
  logic [ADC_BIT-1:0] dout;
  logic               out_ready;
  logic               ovf_clr;
  logic               out_valid;
  logic [ADC_BIT-1:0] out_data;
  logic [AW:0]        level;
  logic               ovf;
  logic [CNT_W-1:0]   conv_cnt;

  int total = 0;
  int bad   = 0;
  logic [ADC_BIT-1:0] exp_q[$];

  sar_dout_fifo #(
    .ADC_BIT(ADC_BIT),
    .DEPTH  (DEPTH),
    .AW     (AW),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rstb     (rstb),
    .ready    (ready),
    .dout     (dout),
    .out_ready(out_ready),
    .ovf_clr  (ovf_clr),
    .out_valid(out_valid),
    .out_data (out_data),
    .level    (level),
    .ovf      (ovf),
    .conv_cnt (conv_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock. If the consumer takes the head at the coming edge,
  // the head is checked against the scoreboard first.
  task automatic tick();
    logic [ADC_BIT-1:0] w;
    if (out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected: got %0h required no word", out_data);
      end else begin
        w = exp_q.pop_front();
        if (out_data !== w) begin
          bad++;
          $display("FAIL pop_data: got %0h required %0h", out_data, w);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // One conversion: ready high for one cycle, then low for one cycle.
  task automatic conv(input logic [ADC_BIT-1:0] w, input bit accepted);
    dout  = w;
    ready = 1'b1;
    if (accepted) exp_q.push_back(w);
    tick();
    ready = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    ready     = 1'b0;
    dout      = '0;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
    rstb      = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rstb = 1'b1;
    tick();
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) tick();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || level !== 3'd0) begin
      bad++;
      $display("FAIL drain_empty: got valid=%0b level=%0d required 0/0", out_valid, level);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (out_valid !== 1'b0 || out_data !== 11'h000 || level !== 3'd0 ||
        ovf !== 1'b0 || conv_cnt !== 8'd0) begin
      bad++;
      $display("FAIL reset_state: got v=%0b d=%0h l=%0d o=%0b c=%0d required 0/0/0/0/0",
               out_valid, out_data, level, ovf, conv_cnt);
    end
  endtask

  task automatic test_single();
    do_reset();
    dout  = 11'b00001000110;
    ready = 1'b1;
    exp_q.push_back(11'h046);
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 11'h046 || level !== 3'd1 || conv_cnt !== 8'd1) begin
      bad++;
      $display("FAIL single_conv: got v=%0b d=%0h l=%0d c=%0d required 1/46/1/1",
               out_valid, out_data, level, conv_cnt);
    end
    ready = 1'b0;
    tick();
    drain(1);
  endtask

  task automatic test_hold();
    do_reset();
    dout  = 11'h123;
    ready = 1'b1;
    exp_q.push_back(11'h123);
    for (int i = 0; i < 5; i++) tick();
    ready = 1'b0;
    tick();
    total++;
    if (level !== 3'd1 || conv_cnt !== 8'd1) begin
      bad++;
      $display("FAIL ready_hold: got l=%0d c=%0d required 1/1", level, conv_cnt);
    end
    drain(1);
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 5; i++) conv(11'(i), i <= 4);
    total++;
    if (level !== 3'd4 || ovf !== 1'b1 || conv_cnt !== 8'd4) begin
      bad++;
      $display("FAIL overflow_state: got l=%0d o=%0b c=%0d required 4/1/4", level, ovf, conv_cnt);
    end
    drain(4);
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 4; i++) conv(11'h10 + 11'(i), 1'b1);
    dout      = 11'h14;
    ready     = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back(11'h14);
    tick();
    ready     = 1'b0;
    out_ready = 1'b0;
    total++;
    if (level !== 3'd4 || ovf !== 1'b0 || conv_cnt !== 8'd5) begin
      bad++;
      $display("FAIL full_push_pop: got l=%0d o=%0b c=%0d required 4/0/5", level, ovf, conv_cnt);
    end
    tick();
    drain(4);
  endtask

  task automatic test_ovf_clr();
    do_reset();
    for (int i = 0; i < 5; i++) conv(11'h200 + 11'(i), i < 4);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    total++;
    if (ovf !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clear: got %0b required 0", ovf);
    end
    dout    = 11'h7FF;
    ready   = 1'b1;
    ovf_clr = 1'b1;
    tick();
    ready   = 1'b0;
    ovf_clr = 1'b0;
    total++;
    if (ovf !== 1'b1 || level !== 3'd4 || conv_cnt !== 8'd4) begin
      bad++;
      $display("FAIL ovf_set_wins: got o=%0b l=%0d c=%0d required 1/4/4", ovf, level, conv_cnt);
    end
    tick();
    drain(4);
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) conv(11'((i * 7) & 11'h7FF), 1'b1);
    out_ready = 1'b0;
    total++;
    if (conv_cnt !== 8'd0 || level !== 3'd0) begin
      bad++;
      $display("FAIL cnt_wrap: got c=%0d l=%0d required 0/0", conv_cnt, level);
    end
    for (int i = 0; i < 3; i++) conv(11'h300 + 11'(i), 1'b1);
    total++;
    if (level !== 3'd3 || conv_cnt !== 8'd3) begin
      bad++;
      $display("FAIL pre_reset_level: got l=%0d c=%0d required 3/3", level, conv_cnt);
    end
    ready = 1'b1;
    dout  = 11'h555;
    #2;
    rstb = 1'b0;
    #1;
    exp_q.delete();
    total++;
    if (out_valid !== 1'b0 || level !== 3'd0) begin
      bad++;
      $display("FAIL async_reset: got v=%0b l=%0d required 0/0", out_valid, level);
    end
    tick();
    rstb = 1'b1;
    tick();
    tick();
    total++;
    if (level !== 3'd0 || conv_cnt !== 8'd0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL stale_ready: got l=%0d c=%0d v=%0b required 0/0/0", level, conv_cnt, out_valid);
    end
    ready = 1'b0;
    tick();
  endtask

  initial begin
    rstb      = 1'b0;
    ready     = 1'b0;
    dout      = '0;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
    test_reset();
    test_single();
    test_hold();
    test_overflow();
    test_full_push_pop();
    test_ovf_clr();
    test_wrap_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
